spi_master_ctrl: RTL

//  Parametrised SPI master: drives SCLK, MOSI and active-low slave selects, and samples MISO.

---
 rtl/spi_master_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master with CPOL/CPHA modes, programmable SCLK divider and MSB/LSB-first order.
// SCLK, MOSI and SS_N are registered outputs generated from the system clock.
module spi_master_ctrl #(
    parameter int unsigned word_width = 8,
    parameter int unsigned SS_width   = 4,
    parameter int unsigned div_width  = 8,
    localparam int unsigned ssv_width = (SS_width > 1) ? $clog2(SS_width) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  CPOL,
    input  logic                  CPHA,
    input  logic                  LSBF,
    input  logic [div_width-1:0]  DIV,
    input  logic [ssv_width-1:0]  SSV,
    input  logic [word_width-1:0] D_IN,
    output logic [word_width-1:0] D_OUT,
    output logic                  busy,
    output logic                  done,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic [SS_width-1:0]   SS_N
);

    localparam int unsigned EW = $clog2(2 * word_width + 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                state;
    logic [div_width-1:0]  cnt;
    logic [div_width-1:0]  div_q;
    logic [EW-1:0]         edges;
    logic [EW-1:0]         edge_next;
    logic                  cpha_q;
    logic                  lsbf_q;
    logic [word_width-1:0] tx_sr;
    logic [word_width-1:0] rx_sr;
    logic                  sample_now;
    logic                  advance_now;

    // Odd toggles are leading edges; CPHA selects which edge parity samples MISO,
    // the other parity advances MOSI (skipping the first leading and last trailing edge).
    always_comb begin
        edge_next   = edges + EW'(1);
        sample_now  = edge_next[0] ^ cpha_q;
        advance_now = !sample_now && (edge_next != EW'(1)) &&
                      (edge_next != EW'(2 * word_width));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            div_q  <= '0;
            edges  <= '0;
            cpha_q <= 1'b0;
            lsbf_q <= 1'b0;
            tx_sr  <= '0;
            rx_sr  <= '0;
            D_OUT  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            SCLK   <= 1'b0;
            MOSI   <= 1'b0;
            SS_N   <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cpha_q <= CPHA;
                        lsbf_q <= LSBF;
                        div_q  <= DIV;
                        tx_sr  <= D_IN;
                        rx_sr  <= '0;
                        MOSI   <= LSBF ? D_IN[0] : D_IN[word_width-1];
                        SCLK   <= CPOL;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        edges  <= '0;
                        for (int unsigned i = 0; i < SS_width; i++) begin
                            SS_N[i] <= (32'(SSV) != i);
                        end
                        state <= SETUP;
                    end
                end
                SETUP, SHIFT: begin
                    if (cnt != div_q) begin
                        cnt <= cnt + div_width'(1);
                    end else begin
                        cnt <= '0;
                        if (state == SHIFT && edges == EW'(2 * word_width)) begin
                            state <= HOLD;
                        end else begin
                            // The end of SETUP doubles as the first SCLK toggle.
                            state <= SHIFT;
                            SCLK  <= ~SCLK;
                            edges <= edge_next;
                            if (sample_now) begin
                                rx_sr <= lsbf_q ? {MISO, rx_sr[word_width-1:1]}
                                                : {rx_sr[word_width-2:0], MISO};
                            end
                            if (advance_now) begin
                                if (lsbf_q) begin
                                    tx_sr <= tx_sr >> 1;
                                    MOSI  <= tx_sr[1];
                                end else begin
                                    tx_sr <= tx_sr << 1;
                                    MOSI  <= tx_sr[word_width-2];
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (cnt != div_q) begin
                        cnt <= cnt + div_width'(1);
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                        SS_N  <= '1;
                        busy  <= 1'b0;
                        D_OUT <= rx_sr;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
